// File: rtl/uart_rx_frame_ctrl_pkg.sv
// uart_rx_frame_ctrl_pkg: shared state encoding and constants for the frame controller
package uart_rx_frame_ctrl_pkg;
  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CHECK   = 3'd3,
    SEND    = 3'd4
  } state_e;
  localparam logic [7:0] SOF_DEF = 8'h7E;
  localparam int CNT_W = 8;
endpackage

// File: rtl/uart_rx_frame_ctrl_sat_counter8.sv
// sat_counter8: increment-enabled event counter that sticks at its maximum value
module sat_counter8
  import uart_rx_frame_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q;
  // count up on each enabled cycle until all ones
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else if (inc_i && cnt_q != '1) cnt_q <= CNT_W'(cnt_q + 1'b1);
  assign cnt_o = cnt_q;
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: assembles SOF/LEN/payload/XOR frames from receiver bytes and streams good payloads
module uart_rx_frame_ctrl
  import uart_rx_frame_ctrl_pkg::*;
#(
  parameter int         MAX_LEN = 15,
  parameter logic [7:0] SOF     = SOF_DEF,
  parameter int         TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_done_tick,
  input  logic [7:0]       rx_data,
  input  logic             rx_perr,
  input  logic             s_tick,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_last,
  output logic             busy,
  output logic [CNT_W-1:0] perr_cnt,
  output logic [CNT_W-1:0] cerr_cnt,
  output logic [CNT_W-1:0] tout_cnt,
  output logic [CNT_W-1:0] ovr_cnt
);
  localparam logic [7:0]  LEN_MAX   = 8'(MAX_LEN);
  localparam logic [15:0] TOUT_LAST = 16'(TIMEOUT - 1);
  state_e      state_q, state_d;
  logic [3:0]  len_q, len_d, idx_q, idx_d, idx_n;
  logic [7:0]  xor_q, xor_d, m_data_q, m_data_d;
  logic        pe_q, pe_d, m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [7:0]  pbuf_q [MAX_LEN];
  logic        perr_inc, cerr_inc, tout_inc, ovr_inc;
  assign idx_n = idx_q + 4'd1;
  // frame sequencing, output staging and drop classification
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    xor_d     = xor_q;
    pe_d      = pe_q;
    tcnt_d    = '0;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    perr_inc  = 1'b0;
    cerr_inc  = 1'b0;
    tout_inc  = 1'b0;
    ovr_inc   = 1'b0;
    case (state_q)
      HUNT: if (rx_done_tick && rx_data == SOF && !rx_perr) state_d = LEN;
      LEN: if (rx_done_tick) begin
        if (rx_perr) begin
          perr_inc = 1'b1;
          state_d  = HUNT;
        end else if (rx_data == 8'd0 || rx_data > LEN_MAX) begin
          cerr_inc = 1'b1;
          state_d  = HUNT;
        end else begin
          len_d   = rx_data[3:0];
          idx_d   = '0;
          xor_d   = '0;
          pe_d    = 1'b0;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: if (rx_done_tick) begin
        xor_d   = xor_q ^ rx_data;
        idx_d   = idx_n;
        pe_d    = pe_q | rx_perr;
        state_d = (idx_q == len_q - 4'd1) ? CHECK : PAYLOAD;
      end
      CHECK: if (rx_done_tick) begin
        if (pe_q || rx_perr) begin
          perr_inc = 1'b1;
          state_d  = HUNT;
        end else if (rx_data != xor_q) begin
          cerr_inc = 1'b1;
          state_d  = HUNT;
        end else begin
          idx_d     = '0;
          m_valid_d = 1'b1;
          m_data_d  = pbuf_q[0];
          m_last_d  = (len_q == 4'd1);
          state_d   = SEND;
        end
      end
      SEND: begin
        ovr_inc = rx_done_tick;
        if (m_ready) begin
          if (m_last_q) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            state_d   = HUNT;
          end else begin
            idx_d    = idx_n;
            m_data_d = pbuf_q[idx_n];
            m_last_d = (idx_n == len_q - 4'd1);
          end
        end
      end
      default: state_d = HUNT;
    endcase
    if ((state_q == LEN || state_q == PAYLOAD || state_q == CHECK) && !rx_done_tick) begin
      if (s_tick && tcnt_q == TOUT_LAST) begin
        tout_inc = 1'b1;
        state_d  = HUNT;
      end else tcnt_d = tcnt_q + 16'(s_tick);
    end
  end
  // state and datapath registers
  always_ff @(posedge clk)
    if (reset) begin
      state_q   <= HUNT;
      len_q     <= '0;
      idx_q     <= '0;
      xor_q     <= '0;
      pe_q      <= 1'b0;
      tcnt_q    <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      xor_q     <= xor_d;
      pe_q      <= pe_d;
      tcnt_q    <= tcnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
    end
  // payload capture; contents are only read after a full frame refills them
  always_ff @(posedge clk)
    if (state_q == PAYLOAD && rx_done_tick) pbuf_q[idx_q] <= rx_data;
  sat_counter8 u_perr (.clk(clk), .rst(reset), .inc_i(perr_inc), .cnt_o(perr_cnt));
  sat_counter8 u_cerr (.clk(clk), .rst(reset), .inc_i(cerr_inc), .cnt_o(cerr_cnt));
  sat_counter8 u_tout (.clk(clk), .rst(reset), .inc_i(tout_inc), .cnt_o(tout_cnt));
  sat_counter8 u_ovr  (.clk(clk), .rst(reset), .inc_i(ovr_inc),  .cnt_o(ovr_cnt));
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign busy    = state_q != HUNT;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: scoreboard bench with frame-level reference model
module tb_uart_rx_frame_ctrl;
  localparam int MAX_LEN = 15;
  localparam int TIMEOUT = 20;
  logic clk = 1'b0, reset = 1'b1;
  logic rx_done_tick = 1'b0, rx_perr = 1'b0, s_tick = 1'b0, m_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic m_valid, m_last, busy;
  logic [7:0] m_data, perr_cnt, cerr_cnt, tout_cnt, ovr_cnt;
  int tests = 0, fails = 0;
  int perr_m = 0, cerr_m = 0, tout_m = 0, ovr_m = 0;
  bit hold = 1'b1, rnd_ready = 1'b0;
  logic [8:0] exp_q[$];
  logic [7:0] q[$];

  uart_rx_frame_ctrl #(.MAX_LEN(MAX_LEN), .SOF(8'h7E), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .rx_perr(rx_perr), .s_tick(s_tick), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .busy(busy), .perr_cnt(perr_cnt),
    .cerr_cnt(cerr_cnt), .tout_cnt(tout_cnt), .ovr_cnt(ovr_cnt));

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return v > 255 ? 255 : v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, " perr_cnt"}, 32'(perr_cnt), 32'(sat(perr_m)));
    chk({tag, " cerr_cnt"}, 32'(cerr_cnt), 32'(sat(cerr_m)));
    chk({tag, " tout_cnt"}, 32'(tout_cnt), 32'(sat(tout_m)));
    chk({tag, " ovr_cnt"},  32'(ovr_cnt),  32'(sat(ovr_m)));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit pe, input int ticks, input bit st);
    repeat (ticks) begin
      s_tick = 1'b1;
      cyc();
    end
    rx_done_tick = 1'b1;
    rx_data = b;
    rx_perr = pe;
    s_tick = st;
    cyc();
    rx_done_tick = 1'b0;
    rx_perr = 1'b0;
    s_tick = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] bs[$], input int pidx);
    foreach (bs[i]) send_byte(bs[i], i == pidx, $urandom % 3, 1'($urandom));
  endtask

  task automatic push_payload(input logic [7:0] bs[$]);
    foreach (bs[i]) exp_q.push_back({i == bs.size() - 1, bs[i]});
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || m_valid) && n < 2000) begin
      cyc();
      n++;
    end
    if (n >= 2000) begin
      tests++;
      fails++;
      $display("FAIL %s idle: busy=%0b after %0d cycles, required 0", tag, busy, n);
    end
  endtask

  // frame-level reference: drop class decided by parity first, then length, then checksum
  task automatic run_frame(input int kind);
    logic [7:0] pl[$];
    logic [7:0] x = 8'h00, lb, ck;
    int len = 1 + $urandom % MAX_LEN;
    int pidx;
    for (int i = 0; i < len; i++) begin
      pl.push_back(($urandom % 8 == 0) ? 8'h7E : 8'($urandom));
      x ^= pl[i];
    end
    send_byte(8'h7E, 1'b0, $urandom % 3, 1'b0);
    if (kind == 4) begin
      lb = ($urandom % 2) ? 8'h00 : 8'(16 + $urandom % 240);
      send_byte(lb, 1'b0, $urandom % 3, 1'b0);
      cerr_m++;
      return;
    end
    if (kind == 2) begin
      send_byte(8'(len), 1'b1, $urandom % 3, 1'b0);
      perr_m++;
      return;
    end
    send_byte(8'(len), 1'b0, ($urandom % 8 == 0) ? TIMEOUT - 1 : $urandom % 3, 1'($urandom));
    pidx = (kind == 1) ? int'($urandom % (len + 1)) : -1;
    foreach (pl[i]) send_byte(pl[i], i == pidx, ($urandom % 8 == 0) ? TIMEOUT - 1 : $urandom % 3, 1'($urandom));
    ck = (kind == 3 || (kind == 1 && $urandom % 2)) ? x ^ 8'(1 + $urandom % 255) : x;
    if (kind == 0) push_payload(pl);
    send_byte(ck, pidx == len, $urandom % 3, 1'($urandom));
    if (kind == 1) perr_m++;
    else if (kind == 3) cerr_m++;
  endtask

  // monitor: drive m_ready, then compare any presented byte with the scoreboard head
  initial forever begin
    @(negedge clk);
    m_ready = hold ? 1'b0 : (rnd_ready ? 1'($urandom) : 1'b1);
    if (!reset && m_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL out_unexpected: got data=%0h last=%0b, required no output", m_data, m_last);
      end else begin
        if ({m_last, m_data} !== exp_q[0]) begin
          fails++;
          $display("FAIL out_data: got last=%0b data=%0h expected last=%0b data=%0h",
                   m_last, m_data, exp_q[0][8], exp_q[0][7:0]);
        end
        if (m_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    repeat (3) cyc();
    chk("reset m_valid", 32'(m_valid), 0);
    chk("reset m_data", 32'(m_data), 0);
    chk("reset m_last", 32'(m_last), 0);
    chk("reset busy", 32'(busy), 0);
    chk_cnts("reset");
    reset = 1'b0;
    hold = 1'b0;
    cyc();
    q = '{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
    exp_q.push_back(9'h011); exp_q.push_back(9'h022); exp_q.push_back(9'h133);
    send_seq(q, -1);
    chk("good busy", 32'(busy), 1);
    wait_idle("good");
    chk_cnts("good");
    exp_q.push_back(9'h011); exp_q.push_back(9'h022); exp_q.push_back(9'h133);
    send_seq(q, -1);
    cyc();
    hold = 1'b1;
    repeat (5) cyc();
    hold = 1'b0;
    wait_idle("backpressure");
    send_seq(q, 3);
    perr_m++;
    wait_idle("parity");
    chk_cnts("parity");
    exp_q.push_back(9'h011); exp_q.push_back(9'h022); exp_q.push_back(9'h133);
    send_seq(q, -1);
    wait_idle("after parity");
    q = '{8'h7E, 8'h02, 8'hAA, 8'hBB, 8'h00};
    send_seq(q, -1);
    cerr_m++;
    chk_cnts("bad checksum");
    q = '{8'h7E, 8'h10};
    send_seq(q, -1);
    cerr_m++;
    chk_cnts("len 16");
    q = '{8'h7E, 8'h00};
    send_seq(q, -1);
    cerr_m++;
    chk_cnts("len 0");
    chk("bad len busy", 32'(busy), 0);
    q = '{8'h7E, 8'h02, 8'hAA};
    send_seq(q, -1);
    repeat (TIMEOUT - 1) begin
      s_tick = 1'b1;
      cyc();
    end
    s_tick = 1'b0;
    chk("pre-timeout busy", 32'(busy), 1);
    s_tick = 1'b1;
    cyc();
    s_tick = 1'b0;
    tout_m++;
    chk("timeout busy", 32'(busy), 0);
    chk_cnts("timeout");
    send_seq(q, -1);
    send_byte(8'hBB, 1'b0, TIMEOUT - 1, 1'b1);
    chk("coincident busy", 32'(busy), 1);
    exp_q.push_back(9'h0AA); exp_q.push_back(9'h1BB);
    send_byte(8'h11, 1'b0, 0, 1'b0);
    wait_idle("coincident");
    chk_cnts("coincident");
    hold = 1'b1;
    run_frame(0);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'($urandom), 1'($urandom), 0, 1'($urandom));
      ovr_m++;
    end
    chk("overrun busy", 32'(busy), 1);
    chk_cnts("overrun");
    hold = 1'b0;
    wait_idle("overrun");
    rnd_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      run_frame($urandom % 5);
      wait_idle("random");
    end
    chk_cnts("random");
    for (int i = 0; i < 300; i++) begin
      send_byte(8'h7E, 1'b0, 0, 1'b0);
      send_byte(8'h03, 1'b1, 0, 1'b0);
      perr_m++;
    end
    chk_cnts("saturate");
    hold = 1'b1;
    run_frame(0);
    cyc();
    cyc();
    reset = 1'b1;
    exp_q.delete();
    cyc();
    reset = 1'b0;
    perr_m = 0; cerr_m = 0; tout_m = 0; ovr_m = 0;
    chk("reset mid-send m_valid", 32'(m_valid), 0);
    chk("reset mid-send busy", 32'(busy), 0);
    chk_cnts("reset mid-send");
    hold = 1'b0;
    run_frame(0);
    wait_idle("final");
    chk("scoreboard drained", 32'(exp_q.size()), 0);
    chk_cnts("final");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
- Frame-level controller that sits directly after the parity-checking UART receiver.
- Consumes its per-byte handshake (rx_done_tick, data byte, parity error flag) and sequences bytes into length-prefixed frames: SOF, LEN, payload, XOR checksum.
- Buffers one payload and commits it only if parity and checksum are clean, then streams it out on a valid/ready interface.
- Drops bad frames, applies an inter-byte timeout counted in receiver oversampling ticks, and keeps saturating error counters.

Parameters:
- MAX_LEN, 15: maximum payload bytes; buffer depth; 1..15.
- SOF, 8'h7E: start-of-frame byte.
- TIMEOUT, 1024: s_tick count without a byte before an open frame is abandoned; 1..65535.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_done_tick  in  1  one-cycle pulse: receiver byte complete
- rx_data  in  8  received byte; valid when rx_done_tick=1
- rx_perr  in  1  parity mismatch for that byte; valid when rx_done_tick=1
- s_tick  in  1  16x baud oversampling tick (shared with receiver)
- m_valid  out  1  output byte valid
- m_ready  in  1  sink accepts byte
- m_data  out  8  payload byte
- m_last  out  1  final payload byte of frame
- busy  out  1  state != HUNT
- perr_cnt  out  8  frames dropped for parity, saturating
- cerr_cnt  out  8  frames dropped for checksum / bad LEN, saturating
- tout_cnt  out  8  frames dropped for timeout, saturating
- ovr_cnt  out  8  bytes received while in SEND, saturating

Behaviour:
- Reset (synchronous): state=HUNT; all counters 0; m_valid=0; m_last=0; m_data=0; busy=0; length, index, XOR and timeout registers 0.
- All registered outputs; no combinational path from rx_* to m_*.
- States:
  - HUNT:
    - On rx_done_tick with rx_data==SOF and rx_perr=0 -> LEN.
    - Other bytes ignored; no counter change.
  - LEN:
    - On rx_done_tick: if rx_perr -> perr_cnt++, HUNT.
    - Else if rx_data==0 or rx_data>MAX_LEN -> cerr_cnt++, HUNT.
    - Else latch len=rx_data[3:0], idx=0, xor=0 -> PAYLOAD.
  - PAYLOAD:
    - On rx_done_tick: buf[idx]=rx_data, xor^=rx_data, idx++.
    - OR rx_perr into a sticky pe flag.
    - When idx reaches len-1 on this byte -> CHECK.
  - CHECK:
    - On rx_done_tick: if pe or rx_perr -> perr_cnt++, HUNT.
    - Else if rx_data!=xor -> cerr_cnt++, HUNT.
    - Else idx=0 -> SEND.
  - SEND:
    - m_valid=1, m_data=buf[idx], m_last=(idx==len-1).
    - On m_valid&m_ready: idx++; on the last byte, m_valid falls next cycle -> HUNT.
    - m_data/m_last stay stable while m_valid=1 and m_ready=0.
- Parity precedence: parity error outranks checksum error; exactly one counter increments per dropped frame.
- Timeout:
  - In LEN/PAYLOAD/CHECK, tcnt increments on each s_tick and clears on rx_done_tick.
  - When tcnt reaches TIMEOUT -> tout_cnt++, HUNT.
  - rx_done_tick in the same cycle wins over timeout.
  - Not active in HUNT or SEND.
- Overrun: rx_done_tick during SEND -> byte discarded, ovr_cnt++. The frame being sent is unaffected; the next SOF is only recognised after return to HUNT.
- SOF byte inside LEN/PAYLOAD/CHECK is ordinary data; no resynchronisation.
- Counters saturate at 8'hFF.
- Reset mid-frame or mid-SEND: frame discarded, m_valid low the cycle after reset asserts.
- Latency: first m_valid one cycle after the rx_done_tick of a good checksum byte.

Decomposition:
- Shared package holds:
  - state encoding constants (HUNT, LEN, PAYLOAD, CHECK, SEND; 3 bits);
  - default SOF;
  - counter width.
- One natural sub-module: sat_counter8 (increment-enable, synchronous reset, saturates at 255), instantiated four times.
- Payload buffer is inline register array (MAX_LEN x 8).

Test Plan:
- Good frame:
  - Stimulus: 7E,03,11,22,33,00 (XOR=00), m_ready=1.
  - Response: m_data 11,22,33 on three consecutive cycles, m_last on 33; all counters 0.
- Backpressure:
  - Stimulus: same frame, m_ready low for 5 cycles at byte 2.
  - Response: m_data=22 held stable, no loss, order preserved.
- Parity error:
  - Stimulus: rx_perr=1 on payload byte 2 of a 3-byte frame.
  - Response: no m_valid; perr_cnt=1; the next good frame delivers normally.
- Bad checksum / bad length:
  - Stimulus: 7E,02,AA,BB,00 (expected 11) -> cerr_cnt=1.
  - Stimulus: 7E,10 -> cerr_cnt=2.
  - Stimulus: 7E,00 -> cerr_cnt=3.
- Timeout:
  - Stimulus: 7E,02,AA then TIMEOUT s_ticks with no byte.
  - Response: tout_cnt=1, busy=0.
  - Stimulus: rx_done_tick coincident with tick number TIMEOUT.
  - Response: no timeout.
- Overrun, saturation and reset:
  - Stimulus: bytes arrive during SEND with m_ready=0.
  - Response: ovr_cnt counts each byte.
  - Stimulus: 300 parity-bad frames.
  - Response: perr_cnt=FF.
  - Stimulus: reset asserted mid-SEND.
  - Response: m_valid=0 next cycle, all counters 0.
